// File: rtl/led_bram_arbiter.sv
// Round-robin arbiter sharing one block-RAM read port among NUM_CH LED strip controllers.
// The winner's local address is offset into its own RAM region, and the read data comes back with a one-cycle ack.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   S_IDLE   | waiting for a request; pick winner, launch the RAM read
//   S_WAIT   | RAM read in flight; count down the read latency, capture data
//   S_RETURN | ch_ack pulse out; requester gets one cycle to drop ch_req
module led_bram_arbiter #(
    parameter int NUM_CH       = 4,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int REGION_BYTES = 1024,
    parameter int RD_LATENCY   = 1
) (
    input  logic                         clk,
    input  logic                         aresetn,
    input  logic [NUM_CH-1:0]            ch_req,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr,
    output logic [NUM_CH-1:0]            ch_ack,
    output logic [DATA_WIDTH-1:0]        ch_rdata,
    output logic                         busy,
    output logic [ADDR_WIDTH-1:0]        bram_addr,
    output logic                         bram_en,
    output logic [3:0]                   bram_web,
    output logic                         bram_rst,
    input  logic [DATA_WIDTH-1:0]        bram_dout
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RETURN} state_t;

    state_t                state_q, state_d;
    logic [CH_W-1:0]       last_q, last_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_CH-1:0]     ch_ack_q, ch_ack_d;
    logic [DATA_WIDTH-1:0] ch_rdata_q, ch_rdata_d;
    logic                  busy_q, busy_d;
    logic [ADDR_WIDTH-1:0] bram_addr_q, bram_addr_d;
    logic                  bram_en_q, bram_en_d;

    logic [ADDR_WIDTH-1:0] addr_arr [NUM_CH];
    logic [CH_W-1:0]       cand;
    logic [CH_W-1:0]       win;
    logic                  req_any;
    logic [ADDR_WIDTH-1:0] win_base;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            addr_arr[i] = ch_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    // Walk from farthest to nearest candidate so the channel right after last_q wins.
    always_comb begin
        win     = last_q;
        req_any = 1'b0;
        cand    = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            cand = CH_W'((int'(last_q) + k) % NUM_CH);
            if (ch_req[cand]) begin
                win     = cand;
                req_any = 1'b1;
            end
        end
    end

    assign win_base = ADDR_WIDTH'(64'(win) * 64'(REGION_BYTES));

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        ch_ack_d    = '0;
        ch_rdata_d  = ch_rdata_q;
        busy_d      = busy_q;
        bram_addr_d = bram_addr_q;
        bram_en_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req_any) begin
                    last_d      = win;
                    bram_addr_d = win_base + addr_arr[win];
                    bram_en_d   = 1'b1;
                    busy_d      = 1'b1;
                    cnt_d       = CNT_W'(RD_LATENCY);
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    ch_rdata_d = bram_dout;
                    ch_ack_d   = NUM_CH'(1) << last_q;
                    state_d    = S_RETURN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RETURN: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q     <= S_IDLE;
            last_q      <= CH_W'(NUM_CH - 1);
            cnt_q       <= '0;
            ch_ack_q    <= '0;
            ch_rdata_q  <= '0;
            busy_q      <= 1'b0;
            bram_addr_q <= '0;
            bram_en_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            ch_ack_q    <= ch_ack_d;
            ch_rdata_q  <= ch_rdata_d;
            busy_q      <= busy_d;
            bram_addr_q <= bram_addr_d;
            bram_en_q   <= bram_en_d;
        end
    end

    assign ch_ack    = ch_ack_q;
    assign ch_rdata  = ch_rdata_q;
    assign busy      = busy_q;
    assign bram_addr = bram_addr_q;
    assign bram_en   = bram_en_q;
    assign bram_web  = 4'b0000;
    assign bram_rst  = 1'b0;
endmodule
